// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO between the SoC UART data register and the UART
// transmitter. Software pushes bytes with one-cycle strobes; the block drains
// them one at a time through the transmitter's sendData/sendReq/ready handshake.
//
// Ports:
//   clk, resetn    clock, asynchronous active-low reset
//   push           one-cycle write strobe; push_data is the byte to enqueue
//   clr_overflow   clears the sticky overflow flag (an overflowing push wins)
//   full / empty   FIFO holds DEPTH bytes / holds nothing and nothing in flight
//   level          number of stored bytes, excluding the in-flight byte
//   overflow       sticky; set when a push arrives while full
//   tx_data        byte presented to the transmitter (holds last sent byte)
//   tx_send        one-cycle send request
//   tx_ready       transmitter idle indication
module uart_tx_fifo #(
  parameter int DEPTH       = 16,
  parameter int LEVEL_BITS  = $clog2(DEPTH) + 1,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  clr_overflow,
  output logic                  full,
  output logic                  empty,
  output logic [LEVEL_BITS-1:0] level,
  output logic                  overflow,
  output logic [7:0]            tx_data,
  output logic                  tx_send,
  input  logic                  tx_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_LOW, WAIT_HIGH} state_e;

  state_e                state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LEVEL_BITS-1:0] count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic [7:0]            mem_q [DEPTH];

  logic push_acc;
  logic pop;

  // full comes from the registered count, so a push arriving while full is
  // dropped even when a pop frees a slot on the same edge.
  assign full     = (count_q == LEVEL_BITS'(DEPTH));
  assign push_acc = push && !full;
  assign pop      = (state_q == IDLE) && (count_q != '0) && tx_ready;

  // State and control registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Storage array carries no reset; only entries between the pointers are valid.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Next-state logic for the drain FSM and its acceptance timer
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = SEND;
        end
      end
      SEND: begin
        state_d = WAIT_LOW;
        timer_d = TMR_W'(ACK_TIMEOUT);
      end
      WAIT_LOW: begin
        // A transmitter that never drops ready is assumed to have taken the
        // byte once the timer runs out.
        if (!tx_ready) begin
          state_d = WAIT_HIGH;
        end else if (timer_q <= TMR_W'(1)) begin
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (tx_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next-state logic for pointers, count, overflow and the output byte
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    tx_data_d  = tx_data_q;

    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      tx_data_d = mem_q[rd_ptr_q];
    end

    unique case ({push_acc, pop})
      2'b10:   count_d = count_q + LEVEL_BITS'(1);
      2'b01:   count_d = count_q - LEVEL_BITS'(1);
      default: count_d = count_q;
    endcase

    // Set has priority over clear.
    if (push && full) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  // Outputs
  always_comb begin
    tx_send  = (state_q == SEND);
    tx_data  = tx_data_q;
    level    = count_q;
    overflow = overflow_q;
    empty    = (count_q == '0) && (state_q == IDLE);
  end

endmodule
